// File: rtl/prime_checker_seq_if.sv
// Handshake/bus bundle for prime_checker_seq: operand in, result out, busy.
interface prime_checker_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_isprime;
  logic             busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_isprime, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_isprime, busy
  );
endinterface

// File: rtl/prime_checker_seq.sv
// Sequential primality checker: trial division by odd divisors d = 3, 5, ...
// while d*d <= n, each division a WIDTH-cycle restoring shift-subtract.
// Optional macro SMALL_LUT_EN: resolve n < 16 in IDLE from a constant table.
module prime_checker_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  prime_checker_seq_if.slave bus
);
  localparam int DW = (WIDTH + 1) / 2 + 1;  // divisor width
  localparam int PW = 2 * DW;               // d*d width, always >= WIDTH+2
  localparam int IW = $clog2(WIDTH);
`ifdef SMALL_LUT_EN
  localparam logic [15:0] SMALL_PRIMES = 16'h28AC;  // bits 2,3,5,7,11,13
`endif

  typedef enum logic [1:0] {S_IDLE, S_SQ, S_DIV, S_DONE} state_t;

  state_t           r_state, w_nstate;
  logic [WIDTH-1:0] r_n;
  logic [DW-1:0]    r_d;
  logic [DW:0]      r_r;
  logic [IW-1:0]    r_idx;
  logic             r_isprime;

  logic             w_acc;
  logic             w_triv, w_triv_prime;
  logic [PW-1:0]    w_sq, w_n_ext;
  logic             w_sq_gt;
  logic [DW:0]      w_r_sh, w_r_nx;
  logic             w_last;

  assign w_acc   = bus.in_valid && (r_state == S_IDLE);
  assign w_sq    = PW'(r_d) * PW'(r_d);
  assign w_n_ext = PW'(r_n);
  assign w_sq_gt = w_sq > w_n_ext;
  assign w_r_sh  = {r_r[DW-1:0], r_n[r_idx]};
  assign w_r_nx  = (w_r_sh >= {1'b0, r_d}) ? (w_r_sh - {1'b0, r_d}) : w_r_sh;
  assign w_last  = (r_idx == '0);

  // Classify operands that need no trial division
  always_comb begin
    w_triv       = 1'b0;
    w_triv_prime = 1'b0;
    if (bus.in_data < WIDTH'(2)) begin
      w_triv = 1'b1;
    end else if (bus.in_data == WIDTH'(2) || bus.in_data == WIDTH'(3)) begin
      w_triv       = 1'b1;
      w_triv_prime = 1'b1;
    end else if (!bus.in_data[0]) begin
      w_triv = 1'b1;
    end
`ifdef SMALL_LUT_EN
    if ((bus.in_data >> 4) == '0) begin
      w_triv       = 1'b1;
      w_triv_prime = SMALL_PRIMES[bus.in_data[3:0]];
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nstate;
  end

  // Next-state logic
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE: if (w_acc) w_nstate = w_triv ? S_DONE : S_SQ;
      S_SQ:   w_nstate = w_sq_gt ? S_DONE : S_DIV;
      S_DIV:  if (w_last) w_nstate = (w_r_nx == '0) ? S_DONE : S_SQ;
      S_DONE: if (bus.out_ready) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Datapath: operand latch, divisor stepping, remainder shift-subtract
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n       <= '0;
      r_d       <= '0;
      r_r       <= '0;
      r_idx     <= '0;
      r_isprime <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_acc) begin
          r_n       <= bus.in_data;
          r_d       <= DW'(3);
          r_isprime <= w_triv_prime;
        end
        S_SQ: begin
          if (w_sq_gt) begin
            r_isprime <= 1'b1;
          end else begin
            r_r   <= '0;
            r_idx <= IW'(WIDTH - 1);
          end
        end
        S_DIV: begin
          r_r   <= w_r_nx;
          r_idx <= r_idx - 1'b1;
          if (w_last && w_r_nx != '0) r_d <= r_d + DW'(2);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.out_data    = r_n;
  assign bus.out_isprime = r_isprime;

endmodule

// File: tb/tb_prime_checker_seq.sv
// Randomized bench for prime_checker_seq (WIDTH=8 plus one WIDTH=16 instance).
module tb_prime_checker_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  prime_checker_seq_if #(.WIDTH(8))  if8 ();
  prime_checker_seq_if #(.WIDTH(16)) if16 ();

  prime_checker_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  prime_checker_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: plain trial division by every integer
  function automatic logic ref_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference latency from the documented per-case formulas
  function automatic int ref_lat(input int n, input int w);
    int k;
    k = 0;
`ifdef SMALL_LUT_EN
    if (n < 16) return 1;
`endif
    if (n < 4 || n % 2 == 0) return 1;
    for (int d = 3; d * d <= n; d += 2) begin
      k++;
      if (n % d == 0) return 1 + k * (w + 1);
    end
    return 2 + k * (w + 1);
  endfunction

  task automatic op8(input int n, input int hold);
    int lat;
    logic ip;
    @(negedge clk);
    chk("in_ready_before", if8.in_ready, 1);
    if8.in_valid = 1'b1;
    if8.in_data  = 8'(n);
    @(posedge clk); #1;
    if8.in_data = 8'($urandom);
    lat = 1;
    while (!if8.out_valid && lat < 5000) begin
      if8.in_valid  = 1'($urandom);   // ignored while busy
      if8.out_ready = 1'($urandom);   // no effect without out_valid
      @(posedge clk); #1;
      lat++;
    end
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b0;
    ip = ref_prime(n);
    chk($sformatf("lat n=%0d", n), lat, ref_lat(n, 8));
    chk($sformatf("prime n=%0d", n), if8.out_isprime, ip);
    chk($sformatf("data n=%0d", n), if8.out_data, n);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", if8.out_valid, 1);
      chk("hold_in_ready", if8.in_ready, 0);
      chk("hold_prime", if8.out_isprime, ip);
      chk("hold_data", if8.out_data, n);
    end
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    chk("post_valid", if8.out_valid, 0);
    chk("post_in_ready", if8.in_ready, 1);
    chk("post_busy", if8.busy, 0);
  endtask

  task automatic op16(input int n);
    int lat;
    @(negedge clk);
    if16.in_valid = 1'b1;
    if16.in_data  = 16'(n);
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    lat = 1;
    while (!if16.out_valid && lat < 10000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("w16 lat n=%0d", n), lat, ref_lat(n, 16));
    chk($sformatf("w16 prime n=%0d", n), if16.out_isprime, ref_prime(n));
    chk($sformatf("w16 data n=%0d", n), if16.out_data, n);
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
    chk("w16 post_in_ready", if16.in_ready, 1);
  endtask

  int dir[] = '{0, 1, 2, 4, 7, 9, 25, 251, 255, 3, 15, 254};

  initial begin
    if8.in_valid = 0;  if8.in_data = 0;  if8.out_ready = 0;
    if16.in_valid = 0; if16.in_data = 0; if16.out_ready = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", if8.in_ready, 1);
    chk("rst_out_valid", if8.out_valid, 0);
    chk("rst_busy", if8.busy, 0);
    chk("rst_isprime", if8.out_isprime, 0);
    chk("rst_out_data", if8.out_data, 0);

    foreach (dir[i]) op8(dir[i], 0);
    op8(25, 5);
    op8(251, 5);

    repeat (40) op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));

    // Reset in the middle of a division pass
    @(negedge clk);
    if8.in_valid = 1'b1;
    if8.in_data  = 8'd251;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("middiv_busy", if8.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", if8.in_ready, 1);
    chk("midrst_out_valid", if8.out_valid, 0);
    chk("midrst_busy", if8.busy, 0);
    chk("midrst_isprime", if8.out_isprime, 0);
    chk("midrst_out_data", if8.out_data, 0);
    op8(13, 0);

    op16(65521);
    op16(65535);
    op16(int'($urandom_range(0, 65535)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
